counter64_ctrl: RTL

- Sequencing controller for the 64-bit counter64 timer datapath used to profile the Hotspot2D kernel.
- Accepts commands (CLEAR, ARM, STOP, SNAP) from the AXI4-Lite register slice.
- Watches kernel start/done pulses and gates the external counter enable/clear, so only kernel-active cycles are accumulated over N invocations.
- Returns counter snapshots over a valid/ready slot and raises a completion interrupt pulse.

---
 rtl/counter64_ctrl_pkg.sv | 25 ++
 rtl/counter64_snap_slot.sv | 34 +++
 rtl/counter64_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/counter64_ctrl_pkg.sv
// counter64_ctrl_pkg
//   Shared types and defaults for the counter64 sequencing controller.
//   state_t : controller FSM encoding (IDLE=0 .. DRAIN=4), exported on state_o.
//   op_t    : command opcodes carried on cmd_op.
package counter64_ctrl_pkg;

  localparam int CNT_W_DEF  = 64;
  localparam int ITER_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_ARM   = 2'b01,
    OP_STOP  = 2'b10,
    OP_SNAP  = 2'b11
  } op_t;

endpackage

// File: rtl/counter64_snap_slot.sv
// counter64_snap_slot
//   Single-entry holding register for counter snapshots.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     load        : capture load_data into the slot (only issued while empty)
//     load_data   : value to capture
//     valid       : slot holds an unconsumed value
//     ready       : consumer takes the value; slot empties on valid && ready
//     data        : captured value, stable while valid
module counter64_snap_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/counter64_ctrl.sv
// counter64_ctrl
//   Sequences an external 64-bit cycle counter so that only kernel-active
//   cycles (between ev_start and ev_done) are accumulated over a programmed
//   number of invocations, then captures the final count and pulses irq.
//   Ports:
//     ACLK, ARESETN        : clock, asynchronous active-low reset
//     cmd_valid/ready/op   : command handshake (CLEAR, ARM, STOP, SNAP)
//     cmd_iters            : invocation target for ARM (0 behaves as 1)
//     ev_start, ev_done    : one-cycle kernel start / done pulses
//     cnt_en, cnt_clr      : counter enable (RUN only) and one-cycle clear
//     cnt_val              : current counter value
//     snap_data/valid/ready: snapshot slot
//     iter_cnt             : completed invocations since ARM
//     state_o              : FSM state for observation
//     irq                  : one-cycle pulse on the final capture
//     err_cmd, err_ovf     : sticky error flags, cleared by CLEAR
//
//   Handshakes: a transfer happens on the rising edge where valid && ready
//   are both high; valid must not depend on ready. cmd_ready drops while the
//   snapshot slot is full or the FSM is draining, so SNAP and the DRAIN
//   capture never compete for the slot.
module counter64_ctrl
  import counter64_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ITER_W = ITER_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ITER_W-1:0] cmd_iters,
  input  logic              ev_start,
  input  logic              ev_done,
  output logic              cnt_en,
  output logic              cnt_clr,
  input  logic [CNT_W-1:0]  cnt_val,
  output logic [CNT_W-1:0]  snap_data,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [2:0]        state_o,
  output logic              irq,
  output logic              err_cmd,
  output logic              err_ovf
);

  state_t            state;
  logic [ITER_W-1:0] target;
  op_t               op;
  logic              cmd_fire;
  logic              ev_blocked;
  logic              snap_load;
  logic [ITER_W-1:0] iter_next;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = !snap_valid && (state != ST_DRAIN);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cnt_en    = (state == ST_RUN);
  assign state_o   = state;

  // CLEAR, STOP and a successful ARM own the state this cycle; kernel events
  // arriving alongside them are dropped. SNAP and a rejected ARM leave the
  // events to be processed normally.
  assign ev_blocked = cmd_fire &&
                      ((op == OP_CLEAR) || (op == OP_STOP) ||
                       ((op == OP_ARM) && (state == ST_IDLE)));

  // Both capture sources share the slot; neither fires while it is full.
  assign snap_load = (cmd_fire && (op == OP_SNAP)) ||
                     ((state == ST_DRAIN) && !snap_valid);

  // Saturating increment; it can never pass target since target <= all ones.
  assign iter_next = (iter_cnt == '1) ? iter_cnt : iter_cnt + ITER_W'(1);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= ST_IDLE;
      target   <= ITER_W'(1);
      iter_cnt <= '0;
      cnt_clr  <= 1'b0;
      irq      <= 1'b0;
      err_cmd  <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      cnt_clr <= 1'b0;
      irq     <= 1'b0;

      if (cnt_en && (&cnt_val)) err_ovf <= 1'b1;

      if (cmd_fire) begin
        case (op)
          OP_CLEAR: begin
            state    <= ST_IDLE;
            cnt_clr  <= 1'b1;
            iter_cnt <= '0;
            err_cmd  <= 1'b0;
            err_ovf  <= 1'b0;
          end
          OP_ARM: begin
            if (state == ST_IDLE) begin
              target   <= (cmd_iters == '0) ? ITER_W'(1) : cmd_iters;
              iter_cnt <= '0;
              state    <= ST_ARMED;
            end else begin
              err_cmd <= 1'b1;
            end
          end
          OP_STOP: begin
            if ((state == ST_ARMED) || (state == ST_RUN) || (state == ST_GAP))
              state <= ST_DRAIN;
          end
          default: ;
        endcase
      end

      if (!ev_blocked) begin
        case (state)
          ST_ARMED, ST_GAP: begin
            if (ev_start) state <= ST_RUN;
          end
          ST_RUN: begin
            if (ev_done) begin
              iter_cnt <= iter_next;
              if (iter_next == target) state <= ST_DRAIN;
              else if (!ev_start)      state <= ST_GAP;
            end
          end
          ST_DRAIN: begin
            // cnt_en is already low here, so cnt_val is the final total.
            if (!snap_valid) begin
              irq   <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  counter64_snap_slot #(.W(CNT_W)) u_slot (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .load      (snap_load),
    .load_data (cnt_val),
    .ready     (snap_ready),
    .valid     (snap_valid),
    .data      (snap_data)
  );

endmodule
